ddr_ctrl_sched: RTL and testbench

//  Top-level DDR4 command-phase controller: sequences IDLE->INIT->RW and arbitrates RW against refresh and MRS update.

---
 rtl/ddr_ctrl_sched_if.sv | 34 +++
 rtl/ddr_ctrl_sched.sv | 163 ++++++++++++++++
 tb/tb_ddr_ctrl_sched.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_ctrl_sched_if.sv
// Signal bundle between the DDR command-phase scheduler and its neighbours
// (init/config block, RW engine, command encoder). slave = scheduler view.
interface ddr_ctrl_sched_if #(
  parameter int NUM_RANKS = 2,
  parameter int MRS_WIDTH = 18
);
  localparam int RANK_W = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1;

  logic                 config_done;
  logic                 rw_idle;
  logic                 mrs_update;
  logic [1:0]           mrs_bl;
  logic [MRS_WIDTH-1:0] mr0;
  logic                 rw_proc;
  logic                 dev_busy;
  logic                 refresh_rdy;
  logic [RANK_W-1:0]    refresh_rank;
  logic                 mrs_update_rdy;
  logic [MRS_WIDTH-1:0] mrs_update_cmd;
  logic [3:0]           refresh_debt;
  logic                 refresh_err;

  modport slave (
    input  config_done, rw_idle, mrs_update, mrs_bl, mr0,
    output rw_proc, dev_busy, refresh_rdy, refresh_rank, mrs_update_rdy,
           mrs_update_cmd, refresh_debt, refresh_err
  );

  modport master (
    output config_done, rw_idle, mrs_update, mrs_bl, mr0,
    input  rw_proc, dev_busy, refresh_rdy, refresh_rank, mrs_update_rdy,
           mrs_update_cmd, refresh_debt, refresh_err
  );
endinterface

// File: rtl/ddr_ctrl_sched.sv
// DDR4 command-phase scheduler: IDLE->INIT->RW sequencing, with multi-rank
// refresh bursts (postponable up to MAX_POSTPONE) and MRS burst-length updates.
module ddr_ctrl_sched #(
  parameter int NUM_RANKS    = 2,
  parameter int T_REFI       = 7800,
  parameter int T_RFC        = 350,
  parameter int T_MOD        = 24,
  parameter int MAX_POSTPONE = 8,
  parameter int MRS_WIDTH    = 18
) (
  input  logic            clock_t,
  input  logic            reset_n,
  ddr_ctrl_sched_if.slave bus
);
  localparam int RANK_W = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1;
  localparam int REFI_W = $clog2(T_REFI);
  localparam int RFC_W  = (T_RFC > 1) ? $clog2(T_RFC) : 1;
  localparam int MOD_W  = (T_MOD > 1) ? $clog2(T_MOD) : 1;

  localparam logic [REFI_W-1:0]    REFI_LAST = REFI_W'(T_REFI - 1);
  localparam logic [RFC_W-1:0]     RFC_LAST  = RFC_W'(T_RFC - 1);
  localparam logic [MOD_W-1:0]     MOD_LAST  = MOD_W'(T_MOD - 1);
  localparam logic [RANK_W-1:0]    RANK_LAST = RANK_W'(NUM_RANKS - 1);
  localparam logic [3:0]           DEBT_MAX  = 4'(MAX_POSTPONE);
  localparam logic [MRS_WIDTH-1:0] BL_MASK   = ~MRS_WIDTH'(3);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_RW      = 3'd2,
    ST_WAIT    = 3'd3,
    ST_REFRESH = 3'd4,
    ST_UPDATE  = 3'd5
  } state_t;

  state_t               state;
  logic [REFI_W-1:0]    refi_cnt;
  logic [RFC_W-1:0]     rfc_cnt;
  logic [MOD_W-1:0]     mod_cnt;
  logic [RANK_W-1:0]    rank_cnt;
  logic [3:0]           debt;
  logic                 err;
  logic                 mrs_pend;
  logic [1:0]           bl_lat;
  logic                 refresh_rdy;
  logic [RANK_W-1:0]    refresh_rank;
  logic                 mrs_update_rdy;
  logic [MRS_WIDTH-1:0] mrs_update_cmd;

  logic       run;
  logic       expire;
  logic       burst_done;
  logic [3:0] debt_nxt;

  // Expiry adds one owed refresh (saturating), a finished burst retires one;
  // both in the same cycle cancel out.
  function automatic logic [3:0] debt_step(input logic [3:0] cur,
                                           input logic       inc,
                                           input logic       dec);
    if (inc && !dec)
      return (cur < DEBT_MAX) ? cur + 4'd1 : cur;
    else if (dec && !inc)
      return (cur != 4'd0) ? cur - 4'd1 : cur;
    else
      return cur;
  endfunction

  assign run        = (state == ST_RW) || (state == ST_WAIT) ||
                      (state == ST_REFRESH) || (state == ST_UPDATE);
  assign expire     = run && (refi_cnt == REFI_LAST);
  assign burst_done = (state == ST_REFRESH) && (rfc_cnt == RFC_LAST) &&
                      (rank_cnt == RANK_LAST);
  assign debt_nxt   = debt_step(debt, expire, burst_done);

  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      refi_cnt       <= '0;
      rfc_cnt        <= '0;
      mod_cnt        <= '0;
      rank_cnt       <= '0;
      debt           <= '0;
      err            <= 1'b0;
      mrs_pend       <= 1'b0;
      bl_lat         <= '0;
      refresh_rdy    <= 1'b0;
      refresh_rank   <= '0;
      mrs_update_rdy <= 1'b0;
      mrs_update_cmd <= '0;
    end else begin
      refresh_rdy    <= 1'b0;
      mrs_update_rdy <= 1'b0;
      refi_cnt       <= (run && !expire) ? refi_cnt + REFI_W'(1) : '0;
      debt           <= debt_nxt;
      if (expire && !burst_done && (debt == DEBT_MAX))
        err <= 1'b1;

      case (state)
        ST_IDLE: state <= ST_INIT;
        ST_INIT: if (bus.config_done) state <= ST_RW;
        ST_RW: begin
          if ((debt == DEBT_MAX) || mrs_pend || ((debt != 4'd0) && bus.rw_idle))
            state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.rw_idle && (debt != 4'd0)) begin
            state        <= ST_REFRESH;
            refresh_rdy  <= 1'b1;
            refresh_rank <= '0;
            rank_cnt     <= '0;
            rfc_cnt      <= '0;
          end else if (bus.rw_idle && mrs_pend) begin
            state          <= ST_UPDATE;
            mrs_update_rdy <= 1'b1;
            mrs_update_cmd <= (bus.mr0 & BL_MASK) | MRS_WIDTH'(bl_lat);
            mrs_pend       <= 1'b0;
            mod_cnt        <= '0;
          end
        end
        ST_REFRESH: begin
          // Each tRFC window ends either in the next rank's REF or, after the
          // last rank, in a fresh burst while debt remains.
          if (rfc_cnt == RFC_LAST) begin
            rfc_cnt <= '0;
            if (rank_cnt != RANK_LAST) begin
              rank_cnt     <= rank_cnt + RANK_W'(1);
              refresh_rank <= rank_cnt + RANK_W'(1);
              refresh_rdy  <= 1'b1;
            end else if (debt_nxt != 4'd0) begin
              rank_cnt     <= '0;
              refresh_rank <= '0;
              refresh_rdy  <= 1'b1;
            end else begin
              state <= ST_RW;
            end
          end else begin
            rfc_cnt <= rfc_cnt + RFC_W'(1);
          end
        end
        ST_UPDATE: begin
          if (mod_cnt == MOD_LAST) state <= ST_RW;
          else                     mod_cnt <= mod_cnt + MOD_W'(1);
        end
        default: state <= ST_IDLE;
      endcase

      // A new request wins over the clear on UPDATE entry so it is not lost.
      if (bus.mrs_update && (state != ST_IDLE) && (state != ST_INIT)) begin
        mrs_pend <= 1'b1;
        bl_lat   <= bus.mrs_bl;
      end
    end
  end

  assign bus.rw_proc        = (state == ST_RW);
  assign bus.dev_busy       = (state != ST_RW);
  assign bus.refresh_rdy    = refresh_rdy;
  assign bus.refresh_rank   = refresh_rank;
  assign bus.mrs_update_rdy = mrs_update_rdy;
  assign bus.mrs_update_cmd = mrs_update_cmd;
  assign bus.refresh_debt   = debt;
  assign bus.refresh_err    = err;
endmodule

// File: tb/tb_ddr_ctrl_sched.sv
// Scoreboard bench for ddr_ctrl_sched: expected refresh/MRS pulses are queued
// with their cycle offset from RW entry and matched by a negedge monitor.
module tb_ddr_ctrl_sched;
  localparam int T_REFI = 64, T_RFC = 8, T_MOD = 6;
  localparam int NUM_RANKS = 2, MAX_POSTPONE = 4, MRS_WIDTH = 18;

  logic clock_t = 1'b0;
  logic reset_n;
  always #5 clock_t = ~clock_t;

  ddr_ctrl_sched_if #(.NUM_RANKS(NUM_RANKS), .MRS_WIDTH(MRS_WIDTH)) bus ();

  ddr_ctrl_sched #(
    .NUM_RANKS(NUM_RANKS), .T_REFI(T_REFI), .T_RFC(T_RFC), .T_MOD(T_MOD),
    .MAX_POSTPONE(MAX_POSTPONE), .MRS_WIDTH(MRS_WIDTH)
  ) dut (
    .clock_t(clock_t),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    bit          is_mrs;
    int          off;
    int          rank;
    logic [17:0] cmd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   r_cyc = 0;

  always @(posedge clock_t) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (offset %0d)", name, act, req, cyc - r_cyc);
    end
  endtask

  task automatic push_ref(input int off, input int rank);
    exp_t e;
    e.is_mrs = 1'b0; e.off = off; e.rank = rank; e.cmd = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_mrs(input int off, input logic [17:0] cmd);
    exp_t e;
    e.is_mrs = 1'b1; e.off = off; e.rank = 0; e.cmd = cmd;
    exp_q.push_back(e);
  endtask

  task automatic step_to(input int off);
    while ((cyc - r_cyc) < off) begin
      @(posedge clock_t);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rw_proc"}, 32'(bus.rw_proc), 32'd0);
    chk({tag, "_dev_busy"}, 32'(bus.dev_busy), 32'd1);
    chk({tag, "_refresh_rdy"}, 32'(bus.refresh_rdy), 32'd0);
    chk({tag, "_refresh_rank"}, 32'(bus.refresh_rank), 32'd0);
    chk({tag, "_mrs_rdy"}, 32'(bus.mrs_update_rdy), 32'd0);
    chk({tag, "_mrs_cmd"}, 32'(bus.mrs_update_cmd), 32'd0);
    chk({tag, "_debt"}, 32'(bus.refresh_debt), 32'd0);
    chk({tag, "_err"}, 32'(bus.refresh_err), 32'd0);
  endtask

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge clock_t) begin
    if (reset_n === 1'b1 && (bus.refresh_rdy === 1'b1 || bus.mrs_update_rdy === 1'b1)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: ref=%0b mrs=%0b at offset %0d, required none",
                 bus.refresh_rdy, bus.mrs_update_rdy, cyc - r_cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_is_mrs", 32'(bus.mrs_update_rdy), 32'(mon_e.is_mrs));
        chk("pulse_is_ref", 32'(bus.refresh_rdy), 32'(!mon_e.is_mrs));
        chk("pulse_offset", 32'(cyc - r_cyc), 32'(mon_e.off));
        if (mon_e.is_mrs) chk("mrs_cmd", 32'(bus.mrs_update_cmd), 32'(mon_e.cmd));
        else              chk("ref_rank", 32'(bus.refresh_rank), 32'(mon_e.rank));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n         = 1'b0;
    bus.config_done = 1'b0;
    bus.rw_idle     = 1'b0;
    bus.mrs_update  = 1'b0;
    bus.mrs_bl      = 2'b00;
    bus.mr0         = '0;
    repeat (3) @(posedge clock_t);
    #1;
    chk_reset_vals("rst");

    // IDLE -> INIT; an MRS request while in INIT must be dropped.
    reset_n = 1'b1;
    @(posedge clock_t);
    #1;
    chk("init_dev_busy", 32'(bus.dev_busy), 32'd1);
    bus.mrs_update = 1'b1;
    bus.mrs_bl     = 2'b11;
    bus.mr0        = 18'h3FFFF;
    @(posedge clock_t);
    #1;
    bus.mrs_update = 1'b0;
    bus.rw_idle    = 1'b1;
    repeat (7) @(posedge clock_t);
    #1;
    chk("init_rw_proc", 32'(bus.rw_proc), 32'd0);
    bus.config_done = 1'b1;
    @(posedge clock_t);
    #1;
    r_cyc = cyc;
    chk("rw_entry_rw_proc", 32'(bus.rw_proc), 32'd1);
    chk("rw_entry_dev_busy", 32'(bus.dev_busy), 32'd0);

    // First expiry with rw_idle steady: one two-rank burst.
    push_ref(66, 0);
    push_ref(74, 1);
    step_to(63);
    chk("t1_debt_before_expiry", 32'(bus.refresh_debt), 32'd0);
    step_to(64);
    chk("t2_debt_after_expiry", 32'(bus.refresh_debt), 32'd1);
    chk("t2_still_rw", 32'(bus.rw_proc), 32'd1);
    step_to(65);
    chk("t2_wait_rw_proc", 32'(bus.rw_proc), 32'd0);
    step_to(82);
    chk("t2_debt_retired", 32'(bus.refresh_debt), 32'd0);
    chk("t2_back_to_rw", 32'(bus.rw_proc), 32'd1);

    // Busy RW engine: debt saturates, refresh forced, then overflow error.
    bus.rw_idle = 1'b0;
    for (int k = 0; k < 8; k++) push_ref(441 + 8 * k, k % 2);
    step_to(320);
    chk("t3_debt_saturated", 32'(bus.refresh_debt), 32'd4);
    chk("t3_rw_before_force", 32'(bus.rw_proc), 32'd1);
    step_to(321);
    chk("t3_forced_wait", 32'(bus.rw_proc), 32'd0);
    step_to(383);
    chk("t3_err_before_overflow", 32'(bus.refresh_err), 32'd0);
    step_to(384);
    chk("t3_err_sticky_set", 32'(bus.refresh_err), 32'd1);
    chk("t3_debt_held", 32'(bus.refresh_debt), 32'd4);
    step_to(440);
    bus.rw_idle = 1'b1;
    step_to(448);
    chk("t3_debt_hold_in_refresh", 32'(bus.refresh_debt), 32'd4);
    step_to(505);
    chk("t3_debt_cleared", 32'(bus.refresh_debt), 32'd0);
    chk("t3_back_to_rw", 32'(bus.rw_proc), 32'd1);

    // Lone MRS update; the expiry inside UPDATE then pulls in a burst.
    push_mrs(508, 18'h3FFF2);
    push_ref(516, 0);
    push_ref(524, 1);
    bus.mrs_update = 1'b1;
    bus.mrs_bl     = 2'b10;
    bus.mr0        = 18'h3FFF0;
    step_to(506);
    bus.mrs_update = 1'b0;
    step_to(508);
    chk("t4_update_busy", 32'(bus.rw_proc), 32'd0);
    step_to(509);
    chk("t4_rdy_one_cycle", 32'(bus.mrs_update_rdy), 32'd0);
    step_to(513);
    chk("t4_tmod_not_done", 32'(bus.rw_proc), 32'd0);
    step_to(514);
    chk("t4_tmod_done", 32'(bus.rw_proc), 32'd1);
    step_to(532);
    chk("t4_debt_after_burst", 32'(bus.refresh_debt), 32'd0);
    bus.rw_idle = 1'b0;

    // Refresh before pending MRS, then a request in the rdy cycle re-arms MRS.
    step_to(580);
    chk("t5_debt_owed", 32'(bus.refresh_debt), 32'd1);
    push_ref(591, 0);
    push_ref(599, 1);
    push_mrs(609, 18'h12345);
    bus.mrs_update = 1'b1;
    bus.mrs_bl     = 2'b01;
    bus.mr0        = 18'h12344;
    step_to(581);
    bus.mrs_update = 1'b0;
    step_to(590);
    chk("t5_waiting", 32'(bus.rw_proc), 32'd0);
    bus.rw_idle = 1'b1;
    step_to(607);
    chk("t5_debt_retired", 32'(bus.refresh_debt), 32'd0);
    chk("t5_rw_between", 32'(bus.rw_proc), 32'd1);
    step_to(609);
    push_mrs(617, 18'h12347);
    push_ref(642, 0);
    bus.mrs_update = 1'b1;
    bus.mrs_bl     = 2'b11;
    step_to(610);
    bus.mrs_update = 1'b0;
    step_to(618);
    bus.mr0 = '0;
    step_to(622);
    chk("t5_cmd_held", 32'(bus.mrs_update_cmd), 32'h12347);
    step_to(623);
    chk("t5_rw_after_second_mrs", 32'(bus.rw_proc), 32'd1);

    // Async reset between rank pulses of a burst.
    step_to(645);
    chk("t6_in_refresh", 32'(bus.rw_proc), 32'd0);
    chk("t6_err_before_reset", 32'(bus.refresh_err), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("t6_async");
    step_to(646);
    chk_reset_vals("t6_held");
    reset_n = 1'b1;
    step_to(647);
    chk("t6_init_busy", 32'(bus.dev_busy), 32'd1);
    step_to(648);
    chk("t6_rw_again", 32'(bus.rw_proc), 32'd1);
    step_to(660);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
